// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter: moves bounded bursts from two source FIFOs into one destination FIFO,
// alternating owners on ties, with look-ahead on the destination flags so it never overflows.
module fifo_burst_arbiter #(
   parameter int DATA_W    = 32,
   parameter int BURST_LEN = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stop,
   input  logic              src0_empty,
   input  logic              src1_empty,
   input  logic              src0_valid,
   input  logic              src1_valid,
   input  logic [DATA_W-1:0] src0_dout,
   input  logic [DATA_W-1:0] src1_dout,
   output logic              src0_rd,
   output logic              src1_rd,
   input  logic              dst_full,
   input  logic              dst_almost_full,
   output logic              dst_wr,
   output logic [DATA_W-1:0] dst_din,
   output logic [1:0]        grant,
   output logic              burst_done
);
   typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;
   localparam logic [7:0] LAST = 8'(BURST_LEN - 1);
   state_t     state;
   logic       owner;
   logic       last_owner;
   logic [7:0] cnt;
   logic       issue;
   logic       own_empty;
   // Writes are blocked in IDLE so a read aborted by reset never reaches the destination.
   always_comb begin
      own_empty  = owner ? src1_empty : src0_empty;
      dst_wr     = (state != IDLE) && (owner ? src1_valid : src0_valid);
      dst_din    = dst_wr ? (owner ? src1_dout : src0_dout) : '0;
      issue      = (state == XFER) && !stop && !dst_full && !(dst_almost_full && dst_wr) && !own_empty;
      src0_rd    = issue && !owner;
      src1_rd    = issue && owner;
      grant      = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
      burst_done = (state == DRAIN);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_owner <= 1'b1;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: if (!stop && !(src0_empty && src1_empty)) begin
               owner <= (!src0_empty && !src1_empty) ? !last_owner : src0_empty;
               cnt   <= '0;
               state <= XFER;
            end
            XFER: begin
               if (issue) cnt <= cnt + 8'd1;
               if ((issue && cnt == LAST) || own_empty) state <= DRAIN;
            end
            DRAIN: begin
               last_owner <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// tb_fifo_burst_arbiter: directed bursts against behavioural source/destination FIFOs,
// with a scoreboard of expected destination writes checked by a negedge monitor.
module tb_fifo_burst_arbiter;
   localparam int W  = 32;
   localparam int BL = 16;
   logic          clk = 1'b0;
   logic          reset;
   logic          stop;
   logic          src0_empty, src1_empty;
   logic          src0_valid = 1'b0, src1_valid = 1'b0;
   logic [W-1:0]  src0_dout = '0, src1_dout = '0;
   logic          src0_rd, src1_rd;
   logic          dst_full, dst_almost_full;
   logic          dst_wr;
   logic [W-1:0]  dst_din;
   logic [1:0]    grant;
   logic          burst_done;
   int            tot[2] = '{0, 0};
   int            ptr[2] = '{0, 0};
   int            eptr[2] = '{0, 0};
   int            dst_cnt = 0;
   int            dst_cap = 64;
   logic          drain = 1'b1;
   logic [W:0]    exp_q[$];
   int            n_chk = 0, n_fail = 0;
   int            bd_cnt = 0, wr_cnt = 0, bd_exp = 0;
   logic          prev_rd = 1'b0;

   fifo_burst_arbiter #(.DATA_W(W), .BURST_LEN(BL)) dut (
      .clk(clk), .reset(reset), .stop(stop),
      .src0_empty(src0_empty), .src1_empty(src1_empty),
      .src0_valid(src0_valid), .src1_valid(src1_valid),
      .src0_dout(src0_dout), .src1_dout(src1_dout),
      .src0_rd(src0_rd), .src1_rd(src1_rd),
      .dst_full(dst_full), .dst_almost_full(dst_almost_full),
      .dst_wr(dst_wr), .dst_din(dst_din),
      .grant(grant), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] word(input int s, input int k);
      return (s != 0 ? 32'hB000_0000 : 32'hA000_0000) + W'(k);
   endfunction

   assign src0_empty      = (ptr[0] == tot[0]);
   assign src1_empty      = (ptr[1] == tot[1]);
   assign dst_full        = (dst_cnt >= dst_cap);
   assign dst_almost_full = (dst_cnt == dst_cap - 1);

   // Source FIFOs answer one cycle after rd; destination fills unless drained.
   always @(posedge clk) begin
      src0_valid <= src0_rd;
      src1_valid <= src1_rd;
      if (src0_rd) begin
         src0_dout <= word(0, ptr[0]);
         ptr[0]    <= ptr[0] + 1;
      end
      if (src1_rd) begin
         src1_dout <= word(1, ptr[1]);
         ptr[1]    <= ptr[1] + 1;
      end
      dst_cnt <= drain ? 0 : dst_cnt + (dst_wr ? 1 : 0);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int s, input int n);
      repeat (n) begin
         exp_q.push_back({s[0], word(s, eptr[s])});
         eptr[s]++;
      end
   endtask

   task automatic wait_bd(input int target, input int budget);
      int i = 0;
      while (bd_cnt < target && i < budget) begin
         step;
         i++;
      end
      chk("burst_done_count", 64'(bd_cnt), 64'(target));
   endtask

   always @(negedge clk) begin
      logic [W:0] e;
      if (reset) prev_rd = 1'b0;
      else begin
         if (src0_rd || src1_rd) chk("rd_owner", 64'(grant), 64'({src1_rd, src0_rd}));
         if (dst_almost_full && dst_wr) chk("af_lookahead_rd", 64'({src0_rd, src1_rd}), 0);
         if (dst_full) chk("full_no_rd_wr", 64'({dst_wr, src0_rd, src1_rd}), 0);
         if (prev_rd || dst_wr) chk("wr_latency", 64'(dst_wr), 64'(prev_rd));
         if (dst_wr) begin
            wr_cnt++;
            if (exp_q.size() == 0) chk("unexpected_wr", 64'(dst_din), 0);
            else begin
               e = exp_q.pop_front();
               chk("wr_data", 64'(dst_din), 64'(e[W-1:0]));
               chk("wr_grant", 64'(grant), e[W] ? 64'd2 : 64'd1);
            end
         end
         if (burst_done) bd_cnt++;
         prev_rd = src0_rd || src1_rd;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i, b, b1, w0, first, last, n;
      reset = 1'b1;
      stop  = 1'b0;
      repeat (3) step;
      chk("reset_outputs", 64'({src0_rd, src1_rd, dst_wr, dst_din, grant, burst_done}), 0);
      reset = 1'b0;
      step;
      chk("post_reset_outputs", 64'({src0_rd, src1_rd, dst_wr, grant, burst_done}), 0);
      // Both sources 40 words: 16/16/16/16 then short 8/8, src0 first.
      tot[0] += 40;
      tot[1] += 40;
      push(0, 16); push(1, 16); push(0, 16); push(1, 16); push(0, 8); push(1, 8);
      bd_exp += 6;
      wait_bd(bd_exp, 400);
      chk("t1_all_written", 64'(exp_q.size()), 0);
      // src1 only, 5 words: consecutive reads, one short burst.
      tot[1] += 5;
      push(1, 5);
      first = -1; last = -1; n = 0;
      for (int c = 0; c < 30; c++) begin
         step;
         if (src1_rd) begin
            if (first < 0) first = c;
            last = c;
            n++;
            chk("t2_grant", 64'(grant), 2'b10);
         end
      end
      chk("t2_reads", 64'(n), 5);
      chk("t2_consecutive", 64'(last - first), 4);
      bd_exp += 1;
      wait_bd(bd_exp, 10);
      // Small destination: look-ahead stops at exactly cap, then held full.
      dst_cap = 4;
      drain = 1'b0;
      tot[0] += 10;
      push(0, 10);
      bd_exp += 1;
      i = 0;
      while (!dst_full && i < 50) begin step; i++; end
      chk("t3_full_reached", 64'(dst_full), 1);
      repeat (10) begin
         step;
         chk("t3_hold_rd", 64'({src0_rd, src1_rd}), 0);
      end
      chk("t3_no_overflow", 64'(dst_cnt), 4);
      drain = 1'b1;
      wait_bd(bd_exp, 60);
      dst_cap = 64;
      chk("t3_all_written", 64'(exp_q.size()), 0);
      // stop after 7 reads of a 16 burst, for 20 cycles.
      b = ptr[0];
      tot[0] += 20;
      push(0, 20);
      w0 = wr_cnt;
      i = 0;
      while (ptr[0] - b < 7 && i < 50) begin step; i++; end
      chk("t4_seven_reads", 64'(ptr[0] - b), 7);
      stop = 1'b1;
      repeat (20) begin
         step;
         chk("t4_stop_rd", 64'({src0_rd, src1_rd}), 0);
      end
      chk("t4_grant_held", 64'(grant), 2'b01);
      chk("t4_inflight_write", 64'(wr_cnt - w0), 7);
      stop = 1'b0;
      bd_exp += 1;
      wait_bd(bd_exp, 60);
      chk("t4_full_burst", 64'(ptr[0] - b), 16);
      bd_exp += 1;
      wait_bd(bd_exp, 60);
      chk("t4_tail_burst", 64'(ptr[0] - b), 20);
      // stop in IDLE blocks grants; then src1 wins the tie, reset aborts it.
      stop = 1'b1;
      tot[0] += 10;
      tot[1] += 10;
      repeat (5) begin
         step;
         chk("idle_stop_grant", 64'(grant), 0);
      end
      b1 = ptr[1];
      push(1, 2);
      stop = 1'b0;
      i = 0;
      while (ptr[1] - b1 < 3 && i < 50) begin step; i++; end
      chk("t5_three_reads", 64'(ptr[1] - b1), 3);
      chk("t5_src1_owner", 64'(grant), 2'b10);
      reset = 1'b1;
      #1;
      chk("t5_async_reset", 64'({grant, src0_rd, src1_rd, dst_wr, burst_done}), 0);
      eptr[1]++;
      step;
      step;
      reset = 1'b0;
      push(0, 10);
      push(1, 7);
      i = 0;
      while (grant == 2'b00 && i < 20) begin step; i++; end
      chk("t5_src0_after_reset", 64'(grant), 2'b01);
      bd_exp += 2;
      wait_bd(bd_exp, 100);
      step;
      chk("final_all_written", 64'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fifo_burst_arbiter.md
FIFO_BURST_ARBITER -- requirements
Module: fifo_burst_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 32, data width of all FIFO ports.
REQ-002 SHALL have parameter BURST_LEN, 16, max reads per grant (legal 2..255).
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stop  input  1  freezes read issue and new grants.
REQ-006 SHALL have ports src0_empty, src1_empty  input  1  source FIFO empty.
REQ-007 SHALL have ports src0_valid, src1_valid  input  1  source read data valid, exactly 1 cycle after rd.
REQ-008 SHALL have ports src0_dout, src1_dout  input  DATA_W  source read data.
REQ-009 SHALL have ports src0_rd, src1_rd  output  1  source read strobe.
REQ-010 SHALL have ports dst_full, dst_almost_full  input  1  destination FIFO status (almost_full = one slot left).
REQ-011 SHALL have port dst_wr  output  1  destination write strobe.
REQ-012 SHALL have port dst_din  output  DATA_W  destination write data.
REQ-013 SHALL have port grant  output  2  one-hot owner, 00 when idle.
REQ-014 SHALL have port burst_done  output  1  one-cycle pulse at end of each burst.

Function
REQ-015 SHALL implement FSM states IDLE, XFER, DRAIN; owner and last_owner are 1-bit registers.
REQ-016 In IDLE with stop=0: both sources non-empty -> owner = !last_owner; one non-empty -> owner = that source; go XFER next cycle; none -> stay IDLE.
REQ-017 In IDLE with stop=1 SHALL stay IDLE regardless of source status.
REQ-018 grant SHALL be one-hot of owner in XFER and DRAIN, 00 in IDLE.
REQ-019 srcN_rd SHALL = XFER & owner==N & !stop & !dst_full & !(dst_almost_full & dst_wr) & !srcN_empty; non-owner rd always 0.
REQ-020 dst_wr SHALL = valid of owner source, combinational; dst_din SHALL = dout of owner source; non-owner valid ignored.
REQ-021 Read counter SHALL clear on entry to XFER and increment per issued rd.
REQ-022 XFER -> DRAIN when rd issued with counter == BURST_LEN-1 (full burst) or owner source empty (short burst); stop=1 alone SHALL NOT end a burst.
REQ-023 DRAIN SHALL last exactly 1 cycle (captures last valid), assert burst_done, load last_owner <= owner, then go IDLE.
REQ-024 No rd SHALL be issued in IDLE or DRAIN; at most one rd per cycle across both sources.
REQ-025 dst_wr SHALL never assert while dst_full=1 given a compliant destination (guaranteed by REQ-019 look-ahead).
REQ-026 stop mid-burst SHALL hold state and counter; issue SHALL resume from same count when stop falls; a write already in flight SHALL complete.
REQ-027 Minimum grant-to-grant overhead SHALL be 2 idle-of-read cycles (DRAIN + IDLE).

Reset
REQ-028 On reset SHALL force IDLE, owner=0, last_owner=1 (src0 wins first tie), counter=0.
REQ-029 During and after reset SHALL drive src0_rd=src1_rd=0, dst_wr=0, dst_din=0 (owner 0 with valid low), grant=00, burst_done=0.
REQ-030 Reset asserted mid-burst SHALL abort immediately; the outstanding read's data is discarded.

Verification
REQ-031 Both sources hold 40 words, dst empty, BURST_LEN=16 -> bursts src0 16, src1 16, src0 16, src1 16, src0 8, src1 8; 80 writes in order per source, 6 burst_done pulses.
REQ-032 src1 only, 5 words -> grant=10, 5 rd on consecutive cycles, short burst, burst_done once, dst receives 5 words with dst_wr 1 cycle after each rd.
REQ-033 dst_almost_full=1 while write in flight -> no rd that cycle; dst_full held 10 cycles -> zero rd, no overflow, burst continues after release.
REQ-034 stop raised after 7 reads of a 16 burst for 20 cycles -> rd=0, grant held, 7th write completes; after release 9 more reads then DRAIN.
REQ-035 reset asserted after 3 reads -> grant=00, rd=0 asynchronously; next grant goes to src0 when both non-empty.
